traffic_light_guard: RTL and testbench

//  Safety monitor and lamp driver placed directly downstream of the traffic-light FSM.

---
 rtl/traffic_light_guard.sv | 197 +++++++++++++++++++
 tb/tb_traffic_light_guard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_guard.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_guard
// Description : Lamp driver and safety monitor behind the traffic-light FSM.
//               Define TRAFFIC_GUARD_ALLRED_EN for steady all-red fault lamps.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_guard #(
  parameter int RED_CYCLES    = 32,
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 7,
  parameter int TOL           = 1,
  parameter int BLINK_HALF    = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             red_in,
  input  logic             yellow_in,
  input  logic             green_in,
  input  logic             fault_clr,
  output logic             lamp_red,
  output logic             lamp_yellow,
  output logic             lamp_green,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [0:0] ST_MONITOR = 1'b0;
  localparam logic [0:0] ST_FAULT   = 1'b1;

  localparam logic [2:0] PH_NONE = 3'b000;
  localparam logic [2:0] PH_R    = 3'b100;
  localparam logic [2:0] PH_Y    = 3'b010;
  localparam logic [2:0] PH_G    = 3'b001;

  localparam logic [2:0] CODE_NONE   = 3'd0;
  localparam logic [2:0] CODE_ONEHOT = 3'd1;
  localparam logic [2:0] CODE_ORDER  = 3'd2;
  localparam logic [2:0] CODE_SHORT  = 3'd3;
  localparam logic [2:0] CODE_LONG   = 3'd4;

  localparam logic [CNT_W-1:0] DWELL_MAX = '1;
  localparam logic [CNT_W-1:0] R_MIN = CNT_W'(RED_CYCLES - TOL);
  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_CYCLES - TOL);
  localparam logic [CNT_W-1:0] Y_MIN = CNT_W'(YELLOW_CYCLES - TOL);
  localparam logic [CNT_W-1:0] R_LIM = CNT_W'(RED_CYCLES + TOL);
  localparam logic [CNT_W-1:0] G_LIM = CNT_W'(GREEN_CYCLES + TOL);
  localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(YELLOW_CYCLES + TOL);

  logic [0:0]       state;
  logic [2:0]       ph_q;     // registered {red, yellow, green}
  logic [2:0]       cur;      // phase whose dwell is being counted; PH_NONE after reset/clear
  logic [CNT_W-1:0] dwell;
  logic             exempt;

  logic             onehot_ok;
  logic             changed;
  logic             order_ok;
  logic [CNT_W-1:0] exp_min;
  logic [CNT_W-1:0] exp_lim;
  logic [2:0]       viol;

  assign onehot_ok = $onehot(ph_q);
  assign changed   = (ph_q != cur);
  assign order_ok  = ((cur == PH_NONE) && (ph_q == PH_R)) ||
                     ((cur == PH_R)    && (ph_q == PH_G)) ||
                     ((cur == PH_G)    && (ph_q == PH_Y)) ||
                     ((cur == PH_Y)    && (ph_q == PH_R));

  always_comb begin
    exp_min = R_MIN;
    exp_lim = R_LIM;
    case (cur)
      PH_G: begin
        exp_min = G_MIN;
        exp_lim = G_LIM;
      end
      PH_Y: begin
        exp_min = Y_MIN;
        exp_lim = Y_LIM;
      end
      default: ;
    endcase
  end

  // Lowest code wins when several checks fire on the same edge.
  always_comb begin
    viol = CODE_NONE;
    if (!onehot_ok) begin
      viol = CODE_ONEHOT;
    end else if (changed) begin
      if (!order_ok) begin
        viol = CODE_ORDER;
      end else if ((cur != PH_NONE) && !exempt && (dwell < exp_min)) begin
        viol = CODE_SHORT;
      end
    end else if (enable && !exempt && (dwell == exp_lim)) begin
      viol = CODE_LONG;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_MONITOR;
      ph_q       <= PH_R;
      cur        <= PH_NONE;
      dwell      <= '0;
      exempt     <= 1'b1;
      fault_code <= CODE_NONE;
      cycle_cnt  <= '0;
    end else begin
      ph_q <= {red_in, yellow_in, green_in};

      // Phase tracking keeps running in FAULT so a clear attempt is judged on live history.
      if (onehot_ok) begin
        if (changed) begin
          cur   <= ph_q;
          dwell <= CNT_W'(1);
          if (cur == PH_R) begin
            exempt <= 1'b0;
          end
        end else if (enable && (dwell != DWELL_MAX)) begin
          dwell <= dwell + CNT_W'(1);
        end
      end

      case (state)
        ST_MONITOR: begin
          if (viol != CODE_NONE) begin
            state      <= ST_FAULT;
            fault_code <= viol;
          end else if ((cur == PH_Y) && (ph_q == PH_R)) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        ST_FAULT: begin
          if (fault_clr && (ph_q == PH_R)) begin
            if (viol != CODE_NONE) begin
              fault_code <= viol;
            end else begin
              state      <= ST_MONITOR;
              fault_code <= CODE_NONE;
              cur        <= PH_NONE;
              dwell      <= '0;
              exempt     <= 1'b1;
            end
          end
        end
        default: state <= ST_MONITOR;
      endcase
    end
  end

  assign fault = (state == ST_FAULT);

`ifdef TRAFFIC_GUARD_ALLRED_EN
  always_comb begin
    {lamp_red, lamp_yellow, lamp_green} = ph_q;
    if (state == ST_FAULT) begin
      {lamp_red, lamp_yellow, lamp_green} = 3'b100;
    end
  end
`else
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic          blink;
  logic [BW-1:0] blink_cnt;

  // Preloaded while monitoring so the first FAULT cycle shows yellow on.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (state == ST_MONITOR) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_comb begin
    {lamp_red, lamp_yellow, lamp_green} = ph_q;
    if (state == ST_FAULT) begin
      {lamp_red, lamp_yellow, lamp_green} = {1'b0, blink, 1'b0};
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_guard
// Description : Vector table, directed corner sequences and random stimulus
//               against a phase-level reference model of traffic_light_guard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_guard;

  localparam int RED_CYCLES    = 32;
  localparam int GREEN_CYCLES  = 20;
  localparam int YELLOW_CYCLES = 7;
  localparam int TOL           = 1;
  localparam int BLINK_HALF    = 4;
  localparam int CNT_W         = 16;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

`ifdef TRAFFIC_GUARD_ALLRED_EN
  localparam logic [2:0] FL = 3'b100;
`else
  localparam logic [2:0] FL = 3'b010;
`endif

  logic             clk = 1'b0;
  logic             reset_n, enable, red_in, yellow_in, green_in, fault_clr;
  logic             lamp_red, lamp_yellow, lamp_green, fault;
  logic [2:0]       fault_code;
  logic [CNT_W-1:0] cycle_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  traffic_light_guard #(
    .RED_CYCLES(RED_CYCLES), .GREEN_CYCLES(GREEN_CYCLES), .YELLOW_CYCLES(YELLOW_CYCLES),
    .TOL(TOL), .BLINK_HALF(BLINK_HALF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .red_in(red_in), .yellow_in(yellow_in), .green_in(green_in), .fault_clr(fault_clr),
    .lamp_red(lamp_red), .lamp_yellow(lamp_yellow), .lamp_green(lamp_green),
    .fault(fault), .fault_code(fault_code), .cycle_cnt(cycle_cnt)
  );

  // Reference model: phases indexed 0=R, 1=G, 2=Y so legal order is (p+1)%3.
  int         exp_len [3];
  logic [2:0] m_q;
  int         m_cur, m_dw, m_code, m_cyc, m_age;
  bit         m_ex, m_flt;

  function automatic int ph_idx(logic [2:0] v);
    case (v)
      3'b100:  return 0;
      3'b001:  return 1;
      3'b010:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] model_lamps();
    if (!m_flt) return m_q;
`ifdef TRAFFIC_GUARD_ALLRED_EN
    return 3'b100;
`else
    return {1'b0, ((m_age / BLINK_HALF) % 2 == 0), 1'b0};
`endif
  endfunction

  task automatic model_step(input logic [2:0] in, input bit en, input bit clr, input bit rst);
    int p, v;
    bit was_yr;
    if (!rst) begin
      m_q = R; m_cur = -1; m_dw = 0; m_ex = 1; m_flt = 0; m_code = 0; m_cyc = 0; m_age = 0;
      return;
    end
    p = ph_idx(m_q);
    v = 0;
    if (p < 0) v = 1;
    else if (p != m_cur) begin
      if (p != ((m_cur < 0) ? 0 : (m_cur + 1) % 3)) v = 2;
      else if (m_cur >= 0 && !m_ex && m_dw < exp_len[m_cur] - TOL) v = 3;
    end else if (en && !m_ex && m_dw + 1 == exp_len[p] + TOL + 1) v = 4;
    was_yr = (m_cur == 2 && p == 0);
    if (p >= 0) begin
      if (p != m_cur) begin
        if (m_cur == 0) m_ex = 0;
        m_cur = p;
        m_dw  = 1;
      end else if (en && m_dw < 65535) m_dw = m_dw + 1;
    end
    if (!m_flt) begin
      if (v != 0) begin m_flt = 1; m_code = v; m_age = 0; end
      else if (was_yr) m_cyc = (m_cyc + 1) % 65536;
    end else begin
      m_age++;
      if (clr && m_q == R) begin
        if (v != 0) m_code = v;
        else begin m_flt = 0; m_code = 0; m_cur = -1; m_dw = 0; m_ex = 1; end
      end
    end
    m_q = in;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drives one cycle, advances the model and compares every output at the falling edge.
  task automatic step(input logic [2:0] in, input bit en, input bit clr, input bit rst);
    {red_in, yellow_in, green_in} = in;
    enable = en; fault_clr = clr; reset_n = rst;
    @(posedge clk);
    model_step(in, en, clr, rst);
    @(negedge clk);
    chk("model_lamps", int'({lamp_red, lamp_yellow, lamp_green}), int'(model_lamps()));
    chk("model_fault", int'(fault), int'(m_flt));
    chk("model_code", int'(fault_code), m_code);
    chk("model_cycle_cnt", int'(cycle_cnt), m_cyc);
  endtask

  task automatic run(input logic [2:0] in, input int n, input bit en);
    for (int i = 0; i < n; i++) step(in, en, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [2:0] in;
    bit         en, clr, rst;
    logic [2:0] lamps;
    bit         flt;
    logic [2:0] code;
  } vec_t;

  vec_t vt [14];

  initial begin
    exp_len[0] = RED_CYCLES; exp_len[1] = GREEN_CYCLES; exp_len[2] = YELLOW_CYCLES;
    reset_n = 1'b0; enable = 1'b1; fault_clr = 1'b0;
    {red_in, yellow_in, green_in} = R;
    model_step(R, 1'b1, 1'b0, 1'b0);

    vt[0]  = '{R,      1, 0, 0, 3'b100, 0, 3'd0};
    vt[1]  = '{R,      1, 0, 1, 3'b100, 0, 3'd0};
    vt[2]  = '{R,      1, 0, 1, 3'b100, 0, 3'd0};
    vt[3]  = '{3'b101, 1, 0, 1, 3'b101, 0, 3'd0};
    vt[4]  = '{R,      1, 0, 1, FL,     1, 3'd1};
    vt[5]  = '{R,      1, 0, 0, 3'b100, 0, 3'd0};
    vt[6]  = '{R,      1, 0, 1, 3'b100, 0, 3'd0};
    vt[7]  = '{Y,      1, 0, 1, 3'b010, 0, 3'd0};
    vt[8]  = '{Y,      1, 0, 1, FL,     1, 3'd2};
    vt[9]  = '{R,      1, 0, 0, 3'b100, 0, 3'd0};
    vt[10] = '{R,      1, 0, 1, 3'b100, 0, 3'd0};
    vt[11] = '{3'b011, 1, 0, 1, 3'b011, 0, 3'd0};
    vt[12] = '{G,      1, 0, 1, FL,     1, 3'd1};
    vt[13] = '{R,      1, 0, 0, 3'b100, 0, 3'd0};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      step(vt[i].in, vt[i].en, vt[i].clr, vt[i].rst);
      chk($sformatf("vec%0d_lamps", i), int'({lamp_red, lamp_yellow, lamp_green}), int'(vt[i].lamps));
      chk($sformatf("vec%0d_fault", i), int'(fault), int'(vt[i].flt));
      chk($sformatf("vec%0d_code", i), int'(fault_code), int'(vt[i].code));
    end

    // Nominal cycle, lamps lag inputs by one cycle.
    run(R, 32, 1);
    step(G, 1, 0, 1);
    chk("lag_green", int'({lamp_red, lamp_yellow, lamp_green}), 1);
    run(G, 19, 1); run(Y, 7, 1); run(R, 3, 1);
    chk("nominal_fault", int'(fault), 0);
    chk("nominal_cycle_cnt", int'(cycle_cnt), 1);

    // Short GREEN, then blink pattern.
    run(R, 29, 1); run(G, 17, 1); run(Y, 1, 1);
    chk("short_pre_fault", int'(fault), 0);
    run(Y, 1, 1);
    chk("short_fault", int'(fault), 1);
    chk("short_code", int'(fault_code), 3);
    for (int k = 1; k <= 8; k++) begin
      run(Y, 1, 1);
`ifdef TRAFFIC_GUARD_ALLRED_EN
      chk($sformatf("allred_age%0d", k), int'({lamp_red, lamp_yellow, lamp_green}), 4);
`else
      chk($sformatf("blink_age%0d", k), int'(lamp_yellow), ((k / 4) % 2 == 0) ? 1 : 0);
`endif
    end

    // Clear attempts: non-RED ignored, RED with a fresh order violation keeps FAULT.
    step(G, 1, 1, 1); step(G, 1, 1, 1);
    chk("clr_green_stays", int'(fault), 1);
    step(R, 1, 0, 1); step(R, 1, 1, 1);
    chk("clr_newviol_fault", int'(fault), 1);
    chk("clr_newviol_code", int'(fault_code), 2);
    step(R, 1, 1, 1);
    chk("clr_ok_fault", int'(fault), 0);
    chk("clr_ok_code", int'(fault_code), 0);
    run(R, 40, 1);
    chk("exempt_red_long", int'(fault), 0);

    // Long YELLOW.
    run(G, 20, 1); run(Y, 9, 1);
    chk("long_pre_fault", int'(fault), 0);
    run(Y, 1, 1);
    chk("long_code", int'(fault_code), 4);

    // enable=0 freezes YELLOW dwell.
    step(R, 1, 0, 0);
    run(R, 32, 1); run(G, 20, 1); run(Y, 3, 1); run(Y, 50, 0); run(Y, 4, 1); run(R, 2, 1);
    chk("freeze_fault", int'(fault), 0);
    chk("freeze_cycle_cnt", int'(cycle_cnt), 1);

    // Reset mid-GREEN and in FAULT.
    run(R, 32, 1); run(G, 5, 1);
    step(G, 1, 0, 0);
    chk("rst_green_lamps", int'({lamp_red, lamp_yellow, lamp_green}), 4);
    chk("rst_green_cnt", int'(cycle_cnt), 0);
    run(Y, 3, 1);
    chk("pre_rst_fault", int'(fault), 1);
    step(Y, 1, 0, 0);
    chk("rst_fault_fault", int'(fault), 0);
    chk("rst_fault_code", int'(fault_code), 0);
    chk("rst_fault_lamps", int'({lamp_red, lamp_yellow, lamp_green}), 4);

    // Random near-legal traffic with glitches, enable drops, clears and rare resets.
    begin
      int ph = 0;
      for (int r = 0; r < 60; r++) begin
        logic [2:0] code_ph;
        int n;
        code_ph = (ph == 0) ? R : (ph == 1) ? G : Y;
        n = exp_len[ph] + int'($urandom_range(0, 4)) - 2;
        for (int c = 0; c < n; c++) begin
          logic [2:0] in;
          in = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 7)) : code_ph;
          step(in, $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 299) != 0);
        end
        ph = (ph + 1) % 3;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
